// File: rtl/jt12_timers_ab_pkg.sv
// Shared constants and state encoding for the FM core Timer A / Timer B block.
package jt12_timers_ab_pkg;

    localparam int unsigned DEF_CNT_A_W   = 10;
    localparam int unsigned DEF_CNT_B_W   = 8;
    localparam int unsigned DEF_PRESC_B_W = 4;

    localparam logic [DEF_CNT_A_W-1:0] TERM_A = '1;
    localparam logic [DEF_CNT_B_W-1:0] TERM_B = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/jt12_timer_cnt.sv
// One up-counting timer: load-edge detect, optional prescaler, reload on
// terminal count, overflow flag and a registered one-cycle overflow pulse.
module jt12_timer_cnt
    import jt12_timers_ab_pkg::*;
#(
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned PRESC_W = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             zero,
    input  logic [CNT_W-1:0] value,
    input  logic             load,
    input  logic             enable_irq,
    input  logic             clr_flag,
    output logic             flag,
    output logic             overflow
);

    localparam int unsigned PW = (PRESC_W == 0) ? 1 : PRESC_W;
    localparam logic [CNT_W-1:0] TERM = '1;

    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             flag_d;
    logic             ovf_c;
    logic             adv_c;

    // Counter advance qualifier: every tick, or only on prescaler wrap
    generate
        if (PRESC_W == 0) begin : g_no_presc
            assign adv_c = 1'b1;
        end else begin : g_presc
            assign adv_c = &presc_q;
        end
    endgenerate

    always_comb begin
        state_d = load ? RUN : IDLE;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        ovf_c   = 1'b0;
        flag_d  = flag;

        // Idle or fresh start holds the reload value; a coincident tick is dropped
        if (!load || state_q == IDLE) begin
            cnt_d   = value;
            presc_d = '0;
        end else if (zero) begin
            presc_d = presc_q + PW'(1);
            if (adv_c) begin
                if (cnt_q == TERM) begin
                    ovf_c = 1'b1;
                    cnt_d = value;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Set beats clear so an overflow is never lost
        if (ovf_c && enable_irq) begin
            flag_d = 1'b1;
        end else if (clr_flag) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            presc_q  <= '0;
            flag     <= 1'b0;
            overflow <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            presc_q  <= presc_d;
            flag     <= flag_d;
            overflow <= ovf_c;
        end
    end

endmodule

// File: rtl/jt12_timers_ab.sv
// Timer A / Timer B pair with the shared registered active-low interrupt.
module jt12_timers_ab
    import jt12_timers_ab_pkg::*;
#(
    parameter int unsigned CNT_A_W   = DEF_CNT_A_W,
    parameter int unsigned CNT_B_W   = DEF_CNT_B_W,
    parameter int unsigned PRESC_B_W = DEF_PRESC_B_W
) (
    input  logic               rst,
    input  logic               clk,
    input  logic               clk_en,
    input  logic               zero,
    input  logic [CNT_A_W-1:0] value_A,
    input  logic [CNT_B_W-1:0] value_B,
    input  logic               load_A,
    input  logic               load_B,
    input  logic               enable_irq_A,
    input  logic               enable_irq_B,
    input  logic               clr_flag_A,
    input  logic               clr_flag_B,
    output logic               flag_A,
    output logic               flag_B,
    output logic               overflow_A,
    output logic               irq_n
);

    logic overflow_b_unused;

    jt12_timer_cnt #(
        .CNT_W   (CNT_A_W),
        .PRESC_W (0)
    ) u_timer_a (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .zero       (zero),
        .value      (value_A),
        .load       (load_A),
        .enable_irq (enable_irq_A),
        .clr_flag   (clr_flag_A),
        .flag       (flag_A),
        .overflow   (overflow_A)
    );

    jt12_timer_cnt #(
        .CNT_W   (CNT_B_W),
        .PRESC_W (PRESC_B_W)
    ) u_timer_b (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .zero       (zero),
        .value      (value_B),
        .load       (load_B),
        .enable_irq (enable_irq_B),
        .clr_flag   (clr_flag_B),
        .flag       (flag_B),
        .overflow   (overflow_b_unused)
    );

    // Interrupt follows the flags one clk_en cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_n <= 1'b1;
        end else if (clk_en) begin
            irq_n <= ~(flag_A | flag_B);
        end
    end

endmodule

// File: tb/tb_jt12_timers_ab.sv
// Directed bench for jt12_timers_ab with hand-computed tick-level expectations.
module tb_jt12_timers_ab;
    import jt12_timers_ab_pkg::*;

    localparam int GAP = 23;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   clk_en = 1'b1;
    logic                   zero = 1'b0;
    logic [DEF_CNT_A_W-1:0] value_A = '0;
    logic [DEF_CNT_B_W-1:0] value_B = '0;
    logic                   load_A = 1'b0;
    logic                   load_B = 1'b0;
    logic                   enable_irq_A = 1'b0;
    logic                   enable_irq_B = 1'b0;
    logic                   clr_flag_A = 1'b0;
    logic                   clr_flag_B = 1'b0;
    logic                   flag_A, flag_B, overflow_A, irq_n;

    int vectors = 0;
    int errors  = 0;

    jt12_timers_ab dut (
        .rst          (rst),
        .clk          (clk),
        .clk_en       (clk_en),
        .zero         (zero),
        .value_A      (value_A),
        .value_B      (value_B),
        .load_A       (load_A),
        .load_B       (load_B),
        .enable_irq_A (enable_irq_A),
        .enable_irq_B (enable_irq_B),
        .clr_flag_A   (clr_flag_A),
        .clr_flag_B   (clr_flag_B),
        .flag_A       (flag_A),
        .flag_B       (flag_B),
        .overflow_A   (overflow_A),
        .irq_n        (irq_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle zero strobe; returns just after the edge that consumed it
    task automatic pulse_tick();
        zero = 1'b1;
        @(negedge clk);
        zero = 1'b0;
    endtask

    task automatic ticks_quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            pulse_tick();
            chk(tag, 32'(overflow_A), 32'd0);
            idle(GAP);
        end
    endtask

    task automatic period(input int n, input string tag);
        for (int i = 1; i <= n; i++) begin
            pulse_tick();
            chk(tag, 32'(overflow_A), 32'(i == n));
            idle(GAP);
        end
    endtask

    initial begin
        idle(3);
        chk("rst_flag_A", 32'(flag_A), 32'd0);
        chk("rst_flag_B", 32'(flag_B), 32'd0);
        chk("rst_ovf", 32'(overflow_A), 32'd0);
        chk("rst_irq_n", 32'(irq_n), 32'd1);
        rst = 1'b0;
        idle(2);

        // Timer A, value 1020: period of 4 ticks, irq lags flag by one cycle
        value_A = 10'd1020;
        enable_irq_A = 1'b1;
        load_A = 1'b1;
        idle(1);
        ticks_quiet(3, "a_first_quiet");
        pulse_tick();
        chk("a_first_ovf", 32'(overflow_A), 32'd1);
        chk("a_first_flag", 32'(flag_A), 32'd1);
        chk("a_irq_lag", 32'(irq_n), 32'd1);
        idle(1);
        chk("a_ovf_one_cycle", 32'(overflow_A), 32'd0);
        chk("a_irq_set", 32'(irq_n), 32'd0);
        idle(GAP - 1);
        period(4, "a_per2");
        period(4, "a_per3");

        // Clear coincident with overflow loses to the set
        ticks_quiet(3, "clr_race_quiet");
        zero = 1'b1;
        clr_flag_A = 1'b1;
        @(negedge clk);
        zero = 1'b0;
        clr_flag_A = 1'b0;
        chk("clr_race_ovf", 32'(overflow_A), 32'd1);
        chk("clr_race_flag", 32'(flag_A), 32'd1);
        idle(GAP);
        clr_flag_A = 1'b1;
        idle(1);
        clr_flag_A = 1'b0;
        chk("clr_flag", 32'(flag_A), 32'd0);
        chk("clr_irq_lag", 32'(irq_n), 32'd0);
        idle(1);
        chk("clr_irq_release", 32'(irq_n), 32'd1);

        // Mid-run value change applies only at the next reload
        value_A = 10'd1000;
        period(4, "a_cur_period");
        period(24, "a_next_period");
        chk("a_flag_reset_again", 32'(flag_A), 32'd1);
        load_A = 1'b0;
        idle(1);
        ticks_quiet(6, "a_stopped");
        chk("a_flag_held", 32'(flag_A), 32'd1);
        chk("a_irq_held", 32'(irq_n), 32'd0);
        clr_flag_A = 1'b1;
        idle(1);
        clr_flag_A = 1'b0;
        idle(1);
        chk("a_flag_cleared", 32'(flag_A), 32'd0);
        chk("a_irq_cleared", 32'(irq_n), 32'd1);

        // Timer B, value 254: overflow every 32 ticks
        value_B = 8'd254;
        enable_irq_B = 1'b0;
        load_B = 1'b1;
        idle(1);
        for (int i = 1; i <= 32; i++) begin
            pulse_tick();
            chk("b_masked_flag", 32'(flag_B), 32'd0);
            chk("b_masked_irq", 32'(irq_n), 32'd1);
            idle(GAP);
        end
        enable_irq_B = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            pulse_tick();
            chk("b_period", 32'(flag_B), 32'(i == 32));
            idle(GAP);
        end
        chk("b_irq", 32'(irq_n), 32'd0);
        clr_flag_B = 1'b1;
        load_B = 1'b0;
        idle(1);
        clr_flag_B = 1'b0;
        chk("b_flag_clr", 32'(flag_B), 32'd0);
        idle(1);
        chk("b_irq_clr", 32'(irq_n), 32'd1);

        // Terminal reload value overflows on every tick
        value_A = TERM_A;
        enable_irq_A = 1'b0;
        load_A = 1'b1;
        idle(1);
        period(1, "a_term_1");
        period(1, "a_term_2");
        period(1, "a_term_3");
        chk("a_term_masked_flag", 32'(flag_A), 32'd0);
        load_A = 1'b0;
        idle(1);

        // Start edge coincident with a tick: that tick is not counted
        value_A = 10'd1020;
        enable_irq_A = 1'b1;
        load_A = 1'b1;
        zero = 1'b1;
        idle(1);
        zero = 1'b0;
        chk("edge_tick_ovf", 32'(overflow_A), 32'd0);
        idle(GAP);
        period(4, "edge_tick_period");

        // Reset mid-count at 1022 with load held high
        ticks_quiet(2, "pre_rst");
        rst = 1'b1;
        pulse_tick();
        chk("mid_rst_flag_A", 32'(flag_A), 32'd0);
        chk("mid_rst_flag_B", 32'(flag_B), 32'd0);
        chk("mid_rst_ovf", 32'(overflow_A), 32'd0);
        chk("mid_rst_irq_n", 32'(irq_n), 32'd1);
        idle(2);
        rst = 1'b0;
        idle(1);
        period(4, "post_rst_period");
        chk("post_rst_flag", 32'(flag_A), 32'd1);

        // clk_en low freezes everything, including the clear strobe
        ticks_quiet(3, "pre_freeze");
        clk_en = 1'b0;
        clr_flag_A = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
            chk("freeze_ovf", 32'(overflow_A), 32'd0);
            chk("freeze_flag", 32'(flag_A), 32'd1);
            chk("freeze_irq", 32'(irq_n), 32'd0);
            idle(2);
        end
        clr_flag_A = 1'b0;
        clk_en = 1'b1;
        pulse_tick();
        chk("thaw_ovf", 32'(overflow_A), 32'd1);
        clk_en = 1'b0;
        idle(1);
        chk("ovf_frozen_high", 32'(overflow_A), 32'd1);
        clk_en = 1'b1;
        idle(1);
        chk("ovf_release", 32'(overflow_A), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
